// File: rtl/armleocpu_divider_sequencer.sv
// armleocpu_divider_sequencer
// Runs RISC-V DIV/DIVU/REM/REMU on top of an unsigned iterative divider.
// Divide-by-zero and signed overflow are answered locally; every other
// request is reduced to unsigned magnitudes, sent to the divider once, and
// sign-corrected on return. A pipeline kill aborts the operation, draining
// an in-flight divide so the divider is never re-fetched while busy.
module armleocpu_divider_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic        div_fetch,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_division_by_zero
);

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_result;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_is_rem;
  logic        r_neg1;
  logic        r_neg2;

  logic        w_accept;
  logic        w_signed;
  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_div_zero;
  logic        w_overflow;
  logic [31:0] w_special_result;
  logic [31:0] w_quot_fixed;
  logic [31:0] w_rem_fixed;
  logic [31:0] w_div_result;

  // The divider is never handed a zero divisor, so its flag carries no information.
  logic w_unused_div_by_zero;
  assign w_unused_div_by_zero = div_division_by_zero;

  // Request decode: operand signs, magnitudes and the locally-resolved cases.
  always_comb begin
    w_accept   = req_valid && req_ready;
    w_signed   = !req_op[0];
    w_neg1     = w_signed && req_rs1[31];
    w_neg2     = w_signed && req_rs2[31];
    // INT_MIN negates to itself, which is the correct unsigned magnitude.
    w_mag1     = w_neg1 ? (~req_rs1 + 32'd1) : req_rs1;
    w_mag2     = w_neg2 ? (~req_rs2 + 32'd1) : req_rs2;
    w_div_zero = (req_rs2 == 32'd0);
    w_overflow = w_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);
    if (w_div_zero) begin
      w_special_result = req_op[1] ? req_rs1 : ALL_ONES;
    end else begin
      w_special_result = req_op[1] ? 32'd0 : INT_MIN;
    end
  end

  // Sign correction of the divider output: quotient sign is the XOR of the
  // operand signs, remainder takes the dividend's sign.
  always_comb begin
    w_quot_fixed = (r_neg1 ^ r_neg2) ? (~div_quotient + 32'd1) : div_quotient;
    w_rem_fixed  = r_neg1 ? (~div_remainder + 32'd1) : div_remainder;
    w_div_result = r_is_rem ? w_rem_fixed : w_quot_fixed;
  end

  // Sequencer FSM with its operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_result   <= 32'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_is_rem   <= 1'b0;
      r_neg1     <= 1'b0;
      r_neg2     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_div_zero || w_overflow) begin
              r_result <= w_special_result;
              r_state  <= S_RESP;
            end else begin
              r_dividend <= w_mag1;
              r_divisor  <= w_mag2;
              r_is_rem   <= req_op[1];
              r_neg1     <= w_neg1;
              r_neg2     <= w_neg2;
              r_state    <= S_ISSUE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // A kill here means the divider was never started.
          r_state <= kill ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (kill) begin
            // Divider finishing in the kill cycle needs no drain.
            r_state <= div_ready ? S_IDLE : S_DRAIN;
          end else if (div_ready) begin
            r_result <= w_div_result;
            r_state  <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          r_state <= div_ready ? S_IDLE : S_DRAIN;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE) && !kill;
  assign busy         = (r_state != S_IDLE);
  assign resp_valid   = (r_state == S_RESP) && !kill;
  assign div_fetch    = (r_state == S_ISSUE) && !kill;
  assign resp_result  = r_result;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_armleocpu_divider_sequencer.sv
// Bench for armleocpu_divider_sequencer: random and directed requests,
// a behavioural unsigned divider with variable latency, and a scoreboard
// fed by the stimulus and drained by an independent response monitor.
module tb_armleocpu_divider_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        kill;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        div_fetch;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        dv_ready;
  logic [31:0] dv_q;
  logic [31:0] dv_r;
  logic [31:0] dv_a;
  logic [31:0] dv_b;
  int          dv_cnt;

  int          checks = 0;
  int          failures = 0;
  int          fetch_cnt = 0;
  int          fixed_lat = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  armleocpu_divider_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill), .busy(busy),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .div_fetch(div_fetch), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(dv_ready), .div_quotient(dv_q), .div_remainder(dv_r),
    .div_division_by_zero(1'b0)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension semantics using 64-bit host arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, res;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: res = sa / sb;
      2'd1: res = ua / ub;
      2'd2: res = sa % sb;
      default: res = ua % ub;
    endcase
    t = res;
    return t[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 40));
      4: return 32'd0 - 32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  // Behavioural divider: ready drops after a fetch, returns after a latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_ready <= 1'b1;
      dv_cnt   <= 0;
      dv_q     <= 32'd0;
      dv_r     <= 32'd0;
      dv_a     <= 32'd0;
      dv_b     <= 32'd0;
    end else if (div_fetch) begin
      dv_ready <= 1'b0;
      dv_a     <= div_dividend;
      dv_b     <= div_divisor;
      dv_q     <= 32'hDEAD_BEEF;
      dv_r     <= 32'hDEAD_BEEF;
      dv_cnt   <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
    end else if (!dv_ready) begin
      if (dv_cnt <= 1) begin
        dv_ready <= 1'b1;
        dv_q     <= (dv_b == 32'd0) ? 32'hFFFF_FFFF : dv_a / dv_b;
        dv_r     <= (dv_b == 32'd0) ? dv_a : dv_a % dv_b;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  // Monitor: fetch legality and scoreboard comparison of every response.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_fetch) begin
        fetch_cnt++;
        checks++;
        if (!dv_ready || div_divisor == 32'd0) begin
          failures++;
          $display("FAIL fetch_legal got=ready:%0b divisor:%h expected=ready:1 divisor:nonzero",
                   dv_ready, div_divisor);
        end
      end
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp got=%h expected=no response", resp_result);
        end else begin
          mon_exp = exp_q.pop_front();
          if (resp_result !== mon_exp) begin
            failures++;
            $display("FAIL resp_result got=%h expected=%h", resp_result, mon_exp);
          end
        end
      end
    end
  end

  // Issue one request, queue its expected result and wait for the response.
  task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input int exp_fetch);
    int  f0;
    int  lat;
    bit  got;
    bit  acc;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!acc) begin
      chk({name, "_accept"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_model(op, a, b));
    f0 = fetch_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; lat = i; break; end
    end
    chk({name, "_resp_seen"}, {31'd0, got}, 32'd1);
    if (!got) exp_q.delete();
    if (exp_lat >= 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_fetch >= 0) chk({name, "_fetches"}, 32'(fetch_cnt - f0), 32'(exp_fetch));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({name, "_resp_result"}, resp_result, 32'd0);
    chk({name, "_div_fetch"}, {31'd0, div_fetch}, 32'd0);
    chk({name, "_div_dividend"}, div_dividend, 32'd0);
    chk({name, "_div_divisor"}, div_divisor, 32'd0);
  endtask

  initial begin
    int f0;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          special;
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; req_op = 2'd0;
    req_rs1 = 32'd0; req_rs2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases from the operation rules.
    run_req("divu_big", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, 1);
    run_req("remu_big", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, 1);
    run_req("div_m20_3", 2'd0, 32'hFFFF_FFEC, 32'd3, -1, 1);
    run_req("rem_m20_3", 2'd2, 32'hFFFF_FFEC, 32'd3, -1, 1);
    run_req("div_20_m3", 2'd0, 32'd20, 32'hFFFF_FFFD, -1, 1);
    run_req("rem_20_m3", 2'd2, 32'd20, 32'hFFFF_FFFD, -1, 1);
    run_req("div_by0", 2'd0, 32'd7, 32'd0, 1, 0);
    run_req("divu_by0", 2'd1, 32'd7, 32'd0, 1, 0);
    run_req("rem_by0", 2'd2, 32'd7, 32'd0, 1, 0);
    run_req("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_req("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_req("divu_ovf_ops", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1);

    // Fixed divider latency L gives response latency L + 3 cycles after accept.
    fixed_lat = 4;
    run_req("divu_lat4", 2'd1, 32'd100, 32'd9, 7, 1);

    // Kill during WAIT: drained, no response, blocked until divider done.
    fixed_lat = 10;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'd1000; req_rs2 = 32'd7;
    chk("killw_ready_before", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    kill = 1'b1;
    #1;
    chk("killw_ready_in_kill", {31'd0, req_ready}, 32'd0);
    chk("killw_busy_in_kill", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    kill = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("killw_busy_drain", {31'd0, busy}, 32'd1);
      chk("killw_ready_drain", {31'd0, req_ready}, 32'd0);
      if (dv_ready) break;
    end
    @(negedge clk);
    chk("killw_idle_after", {31'd0, busy}, 32'd0);
    fixed_lat = 0;
    run_req("after_killw", 2'd1, 32'd21, 32'd3, -1, 1);

    // Kill during ISSUE: no fetch at all.
    f0 = fetch_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd0; req_rs1 = 32'd50; req_rs2 = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    kill = 1'b1;
    #1;
    chk("killi_no_fetch", {31'd0, div_fetch}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("killi_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("killi_fetch_count", 32'(fetch_cnt - f0), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    fixed_lat = 20;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'd999; req_rs2 = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    fixed_lat = 0;
    run_req("after_rst", 2'd1, 32'd106, 32'd53, -1, 1);

    // Randomised operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      special = (b == 32'd0) ||
                (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      run_req("rand", op, a, b, special ? 1 : -1, special ? 0 : 1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
